rst_seq_ctrl: RTL and testbench

//  Single-clock reset sequencer: merges PLL lock loss, debounced push-button and software reset

---
 rtl/rst_seq_ctrl_if.sv | 23 ++
 rtl/rst_seq_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctrl_if.sv
// Bundle of reset-sequencer request inputs and reset/status outputs.
// The master side drives the request sources; the slave side is the sequencer.
interface rst_seq_ctrl_if #(
  parameter int NumRst = 3
);
  logic              pll_locked_i;
  logic              rst_btn_i;
  logic              sw_rst_req_i;
  logic              cause_clr_i;
  logic [NumRst-1:0] rst_no;
  logic              rst_active_o;
  logic [2:0]        rst_cause_o;

  modport master (
    output pll_locked_i, rst_btn_i, sw_rst_req_i, cause_clr_i,
    input  rst_no, rst_active_o, rst_cause_o
  );

  modport slave (
    input  pll_locked_i, rst_btn_i, sw_rst_req_i, cause_clr_i,
    output rst_no, rst_active_o, rst_cause_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: merges PLL-loss, debounced button and software requests,
// holds all reset outputs low, then releases them one by one after a stretch.
module rst_seq_ctrl #(
  parameter int NumRst         = 3,
  parameter int StretchCycles  = 255,
  parameter int StepCycles     = 16,
  parameter int DebounceCycles = 1000
) (
  input logic           clk_i,
  input logic           rst_ni,
  rst_seq_ctrl_if.slave bus
);

  localparam int MaxCnt = (StretchCycles > StepCycles) ? StretchCycles : StepCycles;
  localparam int CntW   = $clog2(MaxCnt + 1);
  localparam int IdxW   = $clog2(NumRst + 1);
  localparam int DbW    = $clog2(DebounceCycles + 1);

  localparam logic [CntW-1:0] StretchLast = CntW'(StretchCycles - 1);
  localparam logic [CntW-1:0] StepLast    = CntW'(StepCycles - 1);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(NumRst - 1);
  localparam logic [DbW-1:0]  DbLast      = DbW'(DebounceCycles - 1);

  typedef enum logic [1:0] {
    HOLD,
    STRETCH,
    RELEASE,
    RUN
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [NumRst-1:0] rst_n_q, rst_n_d;
  logic              active_q, active_d;
  logic [2:0]        cause_q, cause_d;

  logic              lock_meta, lock_sync;
  logic              btn_meta, btn_sync;
  logic              btn_db;
  logic [DbW-1:0]    db_cnt;

  logic [2:0]        src;
  logic              req;

  // Two-flop synchronisers for the asynchronous lock and button inputs.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
      btn_meta  <= 1'b0;
      btn_sync  <= 1'b0;
    end else begin
      lock_meta <= bus.pll_locked_i;
      lock_sync <= lock_meta;
      btn_meta  <= bus.rst_btn_i;
      btn_sync  <= btn_meta;
    end
  end

  // A new button level is accepted only after DebounceCycles consecutive
  // disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (btn_sync != btn_db) begin
      if (db_cnt == DbLast) begin
        btn_db <= btn_sync;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  assign src = {bus.sw_rst_req_i, btn_db, ~lock_sync};
  assign req = |src;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= HOLD;
      cnt_q    <= '0;
      idx_q    <= '0;
      rst_n_q  <= '0;
      active_q <= 1'b1;
      cause_q  <= 3'b001;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rst_n_q  <= rst_n_d;
      active_q <= active_d;
      cause_q  <= cause_d;
    end
  end

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;

    unique case (state_q)
      HOLD: begin
        rst_n_d = '0;
        cnt_d   = '0;
        idx_d   = '0;
        if (!req) state_d = STRETCH;
      end
      STRETCH: begin
        rst_n_d = '0;
        if (req) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else if (cnt_q == StretchLast) begin
          state_d = RELEASE;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RELEASE: begin
        if (req) begin
          // Already-released domains drop back into reset on this same edge.
          state_d = HOLD;
          rst_n_d = '0;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == StepLast) begin
          cnt_d = '0;
          for (int k = 0; k < NumRst; k++) begin
            if (idx_q == IdxW'(k)) rst_n_d[k] = 1'b1;
          end
          if (idx_q == IdxLast) begin
            state_d = RUN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        rst_n_d = '1;
        if (req) begin
          state_d = HOLD;
          rst_n_d = '0;
        end
      end
      default: begin
        state_d = HOLD;
        rst_n_d = '0;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    active_d = (state_d != RUN);

    // Clearing is only honoured in RUN, and a source active on the same edge wins.
    if (bus.cause_clr_i && (state_q == RUN)) cause_d = src;
    else                                     cause_d = cause_q | src;
  end

  assign bus.rst_no       = rst_n_q;
  assign bus.rst_active_o = active_q;
  assign bus.rst_cause_o  = cause_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl against a timing-rule reference model
// (consecutive request-free edges decide how many domains are released).
`timescale 1ns/1ps
module tb_rst_seq_ctrl;

  localparam int N  = 3;
  localparam int S  = 8;
  localparam int T  = 4;
  localparam int D  = 5;
  localparam int RunAt = 1 + S + N * T;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  rst_seq_ctrl_if #(.NumRst(N)) bus ();

  rst_seq_ctrl #(
    .NumRst(N), .StretchCycles(S), .StepCycles(T), .DebounceCycles(D)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state: input delay taps, debounce window, quiet-edge count.
  logic     lk1, lk2, bt1, bt2;
  logic     db_m;
  logic     win[$];
  int       quiet;
  logic [2:0] m_cause;

  always @(posedge clk or negedge rst_n) begin
    logic seen_lock, seen_btn, all_same, was_run, req;
    logic [2:0] src;
    if (!rst_n) begin
      lk1 = 0; lk2 = 0; bt1 = 0; bt2 = 0; db_m = 0;
      win.delete();
      quiet = 0;
      m_cause = 3'b001;
    end else begin
      seen_lock = lk2; seen_btn = bt2;
      lk2 = lk1; lk1 = bus.pll_locked_i;
      bt2 = bt1; bt1 = bus.rst_btn_i;
      src = {bus.sw_rst_req_i, db_m, ~seen_lock};
      req = |src;
      was_run = (quiet >= RunAt);
      if (bus.cause_clr_i && was_run) m_cause = src;
      else                            m_cause = m_cause | src;
      win.push_back(seen_btn);
      if (win.size() > D) void'(win.pop_front());
      if (win.size() == D) begin
        all_same = 1'b1;
        foreach (win[i]) if (win[i] != seen_btn) all_same = 1'b0;
        if (all_same && seen_btn != db_m) db_m = seen_btn;
      end
      if (req) quiet = 0;
      else if (quiet < 1000) quiet = quiet + 1;
    end
  end

  function automatic logic [N-1:0] exp_rstn();
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = (quiet >= 1 + S + (k + 1) * T);
    return r;
  endfunction

  function automatic logic [N+3:0] expv();
    return {exp_rstn(), (quiet < RunAt), m_cause};
  endfunction

  function automatic logic [N+3:0] obs();
    return {bus.rst_no, bus.rst_active_o, bus.rst_cause_o};
  endfunction

  task automatic test_reset();
    bus.pll_locked_i = 1; bus.rst_btn_i = 0; bus.sw_rst_req_i = 0; bus.cause_clr_i = 0;
    @(negedge clk); #2;
    rst_n = 0;
    #1;
    n_checks++;
    if (obs() !== {{N{1'b0}}, 1'b1, 3'b001}) begin
      n_fail++;
      $display("FAIL reset_values: got %b expected %b", obs(), {{N{1'b0}}, 1'b1, 3'b001});
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_power_up();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk); n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL power_up cyc %0d: got %b expected %b", i, obs(), expv());
      end
    end
    n_checks++;
    if ({bus.rst_no, bus.rst_active_o, bus.rst_cause_o} !== {{N{1'b1}}, 1'b0, 3'b001}) begin
      n_fail++; $display("FAIL power_up_final: got %b expected %b", obs(), {{N{1'b1}}, 1'b0, 3'b001});
    end
  endtask

  task automatic test_lock_loss();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL lock_loss cyc %0d: got %b expected %b", i, obs(), expv());
      end
      bus.pll_locked_i = !(i >= 2 && i < 5);
    end
  endtask

  task automatic test_button();
    for (int i = 0; i < 130; i++) begin
      @(negedge clk); n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL button cyc %0d: got %b expected %b", i, obs(), expv());
      end
      bus.rst_btn_i = (i >= 2 && i < 6) || (i >= 40 && i < 60);
    end
  endtask

  task automatic test_sw_pulse();
    for (int i = 0; i < 35; i++) begin
      @(negedge clk); n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL sw_pulse cyc %0d: got %b expected %b", i, obs(), expv());
      end
      bus.sw_rst_req_i = (i == 2);
    end
  endtask

  task automatic test_release_interrupt();
    logic [N-1:0] e;
    bit found = 0;
    bus.sw_rst_req_i = 1;
    @(negedge clk);
    bus.sw_rst_req_i = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk); n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL release_wait cyc %0d: got %b expected %b", i, obs(), expv());
      end
      e = exp_rstn();
      found = e[0] && !e[1];
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL release_wait_timeout: got no partial release expected rst_no[0] released");
    end
    for (int i = 0; i < 35; i++) begin
      bus.sw_rst_req_i = (i == 0);
      @(negedge clk); n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL release_interrupt cyc %0d: got %b expected %b", i, obs(), expv());
      end
    end
    bus.sw_rst_req_i = 0;
  endtask

  task automatic test_cause_clr();
    for (int i = 0; i < 60; i++) begin
      bus.sw_rst_req_i = (i == 0) || (i == 30);
      bus.cause_clr_i  = (i == 0) || (i == 28) || (i == 31);
      @(negedge clk); n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL cause_clr cyc %0d: got %b expected %b", i, obs(), expv());
      end
      if (i == 0) begin
        n_checks++;
        if (bus.rst_cause_o !== 3'b100) begin
          n_fail++; $display("FAIL cause_clr_set_wins: got %b expected 100", bus.rst_cause_o);
        end
      end
    end
    bus.sw_rst_req_i = 0; bus.cause_clr_i = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 149) == 0) bus.pll_locked_i = ~bus.pll_locked_i;
      if ($urandom_range(0, 29) == 0)  bus.rst_btn_i    = ~bus.rst_btn_i;
      bus.sw_rst_req_i = ($urandom_range(0, 119) == 0);
      bus.cause_clr_i  = ($urandom_range(0, 15) == 0);
      @(negedge clk); n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random cyc %0d: got %b expected %b", i, obs(), expv());
      end
    end
    bus.pll_locked_i = 1; bus.rst_btn_i = 0; bus.sw_rst_req_i = 0; bus.cause_clr_i = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); n_checks++;
      if (obs() !== expv()) begin
        n_fail++; $display("FAIL random_settle cyc %0d: got %b expected %b", i, obs(), expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_loss();
    test_button();
    test_sw_pulse();
    test_release_interrupt();
    test_cause_clr();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
